// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the FP execute controller: ALU control codes,
// controller FSM encoding and exception-flag bit positions.
package fp_ctrl_pkg;

  localparam logic [4:0] ALU_FADD      = 5'b00100;
  localparam logic [4:0] ALU_FSUB      = 5'b00111;
  localparam logic [4:0] ALU_FCVT_WU_S = 5'b10100;
  localparam logic [4:0] ALU_FCVT_W_S  = 5'b10101;
  localparam logic [4:0] ALU_FCVT_S_WU = 5'b10110;
  localparam logic [4:0] ALU_FCVT_S_W  = 5'b10111;
  localparam logic [4:0] ALU_FMIN      = 5'b01011;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Flag vector layout is {NV,DZ,OF,UF,NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

endpackage

// File: rtl/fp_op_classifier.sv
// Decides whether an FP-class ALU control code needs the iterative FPU
// (add/sub and int<->float conversions) or completes in a single cycle.
module fp_op_classifier
  import fp_ctrl_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] i_alu_ctrl,
  output logic            o_is_multi
);

  always_comb begin
    o_is_multi = (i_alu_ctrl == OP_W'(ALU_FADD))      ||
                 (i_alu_ctrl == OP_W'(ALU_FSUB))      ||
                 (i_alu_ctrl == OP_W'(ALU_FCVT_WU_S)) ||
                 (i_alu_ctrl == OP_W'(ALU_FCVT_W_S))  ||
                 (i_alu_ctrl == OP_W'(ALU_FCVT_S_WU)) ||
                 (i_alu_ctrl == OP_W'(ALU_FCVT_S_W));
  end

endmodule

// File: rtl/fp_exec_ctrl.sv
// Execute-stage sequencer between the ALU decoder and an iterative FPU:
// starts multi-cycle ops, stalls the core until done/timeout, gates the write, keeps sticky fflags.
module fp_exec_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int OP_W    = 5,
  parameter int FLAG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   alu_ctrl,
  input  logic              cache_stall,
  input  logic              fpu_done,
  input  logic [FLAG_W-1:0] fpu_exc,
  input  logic              fflags_clr,
  output logic              fpu_start,
  output logic [OP_W-1:0]   fpu_op,
  output logic              stall_core,
  output logic              result_we,
  output logic [FLAG_W-1:0] fflags,
  output logic              busy,
  output logic              timeout_err
);

  localparam int             CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [OP_W-1:0]   r_op;
  logic [CNT_W-1:0]  r_lat;
  logic [FLAG_W-1:0] r_fflags;
  logic              r_tmo;
  logic [FLAG_W-1:0] r_exc;

  logic [1:0]        w_state_nx;
  logic [CNT_W-1:0]  w_lat_nx;
  logic [OP_W-1:0]   w_op_nx;
  logic              w_cap;
  logic [FLAG_W-1:0] w_cap_exc;
  logic              w_tmo_set;
  logic [FLAG_W-1:0] w_inc_exc;
  logic [FLAG_W-1:0] w_fflags_nx;
  logic              w_is_multi;
  logic              w_accept;
  logic              w_idle;
  logic              w_single_we;
  logic              w_done_we;

  fp_op_classifier #(.OP_W(OP_W)) u_classifier (
    .i_alu_ctrl (alu_ctrl),
    .o_is_multi (w_is_multi)
  );

  assign w_accept    = issue_valid & ~cache_stall;
  assign w_idle      = (r_state == ST_IDLE);
  assign w_single_we = w_idle & w_accept & ~w_is_multi;
  assign w_done_we   = (r_state == ST_DONE) & ~cache_stall;

  always_comb begin
    w_state_nx = r_state;
    w_lat_nx   = r_lat;
    w_op_nx    = r_op;
    w_cap      = 1'b0;
    w_cap_exc  = '0;
    w_tmo_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_multi) begin
          w_state_nx = ST_START;
          w_op_nx    = alu_ctrl;
        end
      end
      ST_START: begin
        w_state_nx = ST_WAIT;
        w_lat_nx   = '0;
      end
      ST_WAIT: begin
        w_lat_nx = r_lat + 1'b1;
        // A done arriving on the last permitted cycle still wins over the timeout
        if (fpu_done) begin
          w_state_nx = ST_DONE;
          w_cap      = 1'b1;
          w_cap_exc  = fpu_exc;
        end else if (r_lat == LAT_LAST) begin
          w_state_nx         = ST_DONE;
          w_cap              = 1'b1;
          w_cap_exc[FLAG_NV] = 1'b1;
          w_tmo_set          = 1'b1;
        end
      end
      ST_DONE: begin
        if (!cache_stall) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Clear wipes only the previously accumulated flags; this cycle's flags survive
  always_comb begin
    w_inc_exc = '0;
    if (w_single_we)    w_inc_exc = fpu_exc;
    else if (w_done_we) w_inc_exc = r_exc;
    w_fflags_nx = (fflags_clr ? '0 : r_fflags) | w_inc_exc;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_lat    <= '0;
      r_fflags <= '0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_op     <= w_op_nx;
      r_lat    <= w_lat_nx;
      r_fflags <= w_fflags_nx;
      r_tmo    <= r_tmo | w_tmo_set;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_cap) r_exc <= w_cap_exc;
  end

  // Combinational outputs are held low while reset is asserted
  assign fpu_start   = RST & (r_state == ST_START);
  assign fpu_op      = RST ? (w_idle ? alu_ctrl : r_op) : '0;
  assign stall_core  = RST & ((w_idle & w_accept & w_is_multi) |
                              (r_state == ST_START) | (r_state == ST_WAIT));
  assign result_we   = RST & (w_single_we | w_done_we);
  assign fflags      = r_fflags;
  assign busy        = ~w_idle;
  assign timeout_err = r_tmo;

endmodule

// File: tb/tb_fp_exec_ctrl.sv
// Scoreboard bench for fp_exec_ctrl: a transaction-level model predicts per-cycle control
// outputs and result-write cycles; a monitor compares them as the DUT presents them.
module tb_fp_exec_ctrl;

  localparam int TMO = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       issue_valid, cache_stall, fpu_done, fflags_clr;
  logic [4:0] alu_ctrl, fpu_exc;
  logic       fpu_start, stall_core, result_we, busy, timeout_err;
  logic [4:0] fpu_op, fflags;

  fp_exec_ctrl #(.TIMEOUT(TMO), .OP_W(5), .FLAG_W(5)) dut (
    .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .alu_ctrl(alu_ctrl),
    .cache_stall(cache_stall), .fpu_done(fpu_done), .fpu_exc(fpu_exc),
    .fflags_clr(fflags_clr), .fpu_start(fpu_start), .fpu_op(fpu_op),
    .stall_core(stall_core), .result_we(result_we), .fflags(fflags),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    bit         stall;
    bit         start;
    bit         busy;
    bit         chk_op;
    logic [4:0] op;
    logic [4:0] flags;
    bit         tmo;
  } cyc_t;

  cyc_t       cq[$];
  int         rq[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [4:0] m_flags = '0;
  bit         m_tmo = 1'b0;
  logic [4:0] multi_codes[6] = '{5'b00100, 5'b00111, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_multi(input logic [4:0] code);
    for (int i = 0; i < 6; i++) if (multi_codes[i] == code) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] rand_single();
    logic [4:0] c;
    do c = 5'($urandom_range(0, 31)); while (is_multi(c));
    return c;
  endfunction

  function automatic logic [4:0] rand_multi();
    return multi_codes[$urandom_range(0, 5)];
  endfunction

  function automatic logic [4:0] rexc();
    return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(1, 31)) : 5'b0;
  endfunction

  // Monitor: per-cycle expectations plus result-write events
  always @(negedge CLK) begin
    cyc_t e;
    if (RST === 1'b1) begin
      if (cq.size() > 0) begin
        e = cq.pop_front();
        chk("stall_core", stall_core, e.stall);
        chk("fpu_start", fpu_start, e.start);
        chk("busy", busy, e.busy);
        if (e.chk_op) chk("fpu_op", fpu_op, e.op);
        chk("fflags", fflags, e.flags);
        chk("timeout_err", timeout_err, e.tmo);
      end
      if (result_we === 1'b1) begin
        if (rq.size() == 0) chk("result_we_unexpected", 1, 0);
        else chk("result_we_cycle", cyc, rq.pop_front());
      end else if (rq.size() > 0 && rq[0] <= cyc) begin
        chk("result_we_missing", 0, 1);
        void'(rq.pop_front());
      end
    end
  end

  task automatic step(input bit iv, input logic [4:0] op, input bit cs, input bit done,
                      input logic [4:0] exc, input bit clr,
                      input bit e_stall, input bit e_start, input bit e_busy);
    cyc_t t;
    @(posedge CLK); #1;
    issue_valid = iv; alu_ctrl = op; cache_stall = cs;
    fpu_done = done; fpu_exc = exc; fflags_clr = clr;
    t.cyc = cyc; t.stall = e_stall; t.start = e_start; t.busy = e_busy;
    t.chk_op = iv; t.op = op; t.flags = m_flags; t.tmo = m_tmo;
    cq.push_back(t);
  endtask

  task automatic do_gap(input bit clr, input bit done);
    step(1'b0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), done, rexc(), clr, 0, 0, 0);
    if (clr) m_flags = '0;
  endtask

  task automatic do_single(input logic [4:0] op, input logic [4:0] exc, input int nstall,
                           input bit clr);
    repeat (nstall) step(1'b1, op, 1'b1, 1'b0, rexc(), 1'b0, 0, 0, 0);
    step(1'b1, op, 1'b0, 1'b0, exc, clr, 0, 0, 0);
    m_flags = (clr ? 5'b0 : m_flags) | exc;
    rq.push_back(cyc);
  endtask

  // lat = cycles in WAIT until done; lat = 0 means the FPU never answers
  task automatic do_multi(input logic [4:0] op, input logic [4:0] exc, input int lat,
                          input int nstall_iss, input int nstall_done, input bit clr_done);
    int w;
    bit c;
    repeat (nstall_iss) step(1'b1, op, 1'b1, 1'b0, rexc(), 1'b0, 0, 0, 0);
    step(1'b1, op, 1'b0, 1'b0, rexc(), 1'b0, 1, 0, 0);
    step(1'b1, op, 1'b0, 1'b0, rexc(), 1'b0, 1, 1, 1);
    w = (lat == 0) ? TMO : lat;
    for (int i = 1; i <= w; i++) begin
      c = ($urandom_range(0, 7) == 0);
      step(1'b1, op, 1'b0, (lat != 0 && i == lat), (i == lat) ? exc : rexc(), c, 1, 0, 1);
      if (c) m_flags = '0;
    end
    if (lat == 0) m_tmo = 1'b1;
    repeat (nstall_done)
      step(1'b1, op, 1'b1, 1'($urandom_range(0, 1)), rexc(), 1'b0, 0, 0, 1);
    step(1'b1, op, 1'b0, 1'b0, rexc(), clr_done, 0, 0, 1);
    m_flags = (clr_done ? 5'b0 : m_flags) | ((lat == 0) ? 5'b10000 : exc);
    rq.push_back(cyc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fpu_start"}, fpu_start, 0);
    chk({tag, "_fpu_op"}, fpu_op, 0);
    chk({tag, "_stall_core"}, stall_core, 0);
    chk({tag, "_result_we"}, result_we, 0);
    chk({tag, "_fflags"}, fflags, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0;
    issue_valid = 1'b1; alu_ctrl = 5'b00100; cache_stall = 1'b0;
    fpu_done = 1'b0; fpu_exc = 5'b11111; fflags_clr = 1'b0;
    #1 chk_all_zero("reset");
    issue_valid = 1'b0; fpu_exc = '0;
    @(negedge CLK); @(negedge CLK); #2 RST = 1'b1;

    // Directed scenarios
    do_single(5'b01011, 5'b10000, 0, 1'b0);
    do_gap(1'b0, 1'b0);
    do_multi(5'b00100, 5'b00001, 4, 0, 0, 1'b1);
    do_gap(1'b0, 1'b1);
    do_multi(5'b00111, 5'b00000, 0, 0, 0, 1'b0);
    do_gap(1'b0, 1'b0);
    do_multi(5'b10110, 5'b01000, 3, 2, 3, 1'b0);
    do_multi(5'b10100, 5'b00010, TMO, 0, 1, 1'b0);
    do_single(5'b01011, 5'b00011, 1, 1'b1);
    do_single(5'b01100, 5'b00100, 0, 1'b1);
    do_gap(1'b0, 1'b0);

    // Reset in the middle of WAIT, then a late done must be ignored
    step(1'b1, 5'b00111, 1'b0, 1'b0, 5'b0, 1'b0, 1, 0, 0);
    step(1'b1, 5'b00111, 1'b0, 1'b0, 5'b0, 1'b0, 1, 1, 1);
    step(1'b1, 5'b00111, 1'b0, 1'b0, 5'b0, 1'b0, 1, 0, 1);
    step(1'b1, 5'b00111, 1'b0, 1'b0, 5'b0, 1'b0, 1, 0, 1);
    @(negedge CLK); #1 RST = 1'b0;
    #1 chk_all_zero("midreset");
    issue_valid = 1'b0; fpu_done = 1'b0; fflags_clr = 1'b0; cache_stall = 1'b0;
    m_flags = '0; m_tmo = 1'b0;
    @(posedge CLK); @(negedge CLK); #2 RST = 1'b1;
    step(1'b0, 5'b00111, 1'b0, 1'b1, 5'b11111, 1'b0, 0, 0, 0);
    do_gap(1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2))
        do_gap($urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1)
        do_single(rand_single(), rexc(),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0,
                  $urandom_range(0, 3) == 0);
      else
        do_multi(rand_multi(), rexc(),
                 ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TMO),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0,
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                 $urandom_range(0, 3) == 0);
    end
    do_gap(1'b0, 1'b0);
    do_gap(1'b0, 1'b0);
    @(negedge CLK); #1;
    chk("pending_results", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
